uart_rx_packer: RTL and testbench

- Sits directly downstream of the UART receiver. Consumes its rx_done_tick/dout byte strobe.
- Packs bytes little-endian into 32-bit words. Flushes partial words after an idle timeout.
- Queues words in a small word FIFO that the CPU reads through a memory-mapped window.
- Lets software fetch four received bytes per load instead of one.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_packer_word_fifo.sv | 66 ++++++
 rtl/uart_rx_packer.sv | 134 +++++++++++++
 tb/tb_uart_rx_packer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Register offsets, bit positions and the FIFO entry layout for the UART byte packer.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int LEVEL_LSB = 0;
  localparam int EMPTY_BIT = 8;
  localparam int FULL_BIT  = 9;
  localparam int OVR_BIT   = 10;
  localparam int BCNT_LSB  = 11;

  localparam int CLR_OVR_BIT = 0;
  localparam int FLUSH_BIT   = 1;

  typedef struct packed {
    logic [2:0]  bcnt;
    logic [31:0] data;
  } word_t;

endpackage

// File: rtl/uart_rx_packer_word_fifo.sv
// Word FIFO, combinational head; push is accepted when full only alongside a pop.
// Flush empties it and overrides any push or pop in the same cycle.
module word_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      lvl_q, lvl_d;
  logic             push_ok, pop_ok;

  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == (AW+1)'(DEPTH));
  assign level   = lvl_q;
  assign dout    = mem_q[rd_q];
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (pop_ok) rd_d = rd_q + 1'b1;
      lvl_d = lvl_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received bytes little-endian into 32-bit words, flushing partial words after an idle timeout.
// Word readable one cycle after its last byte; a push into a full FIFO without a pop is dropped and flagged.
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_done_tick,
  input  logic [7:0]  rx_data,
  input  logic [15:0] address,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        irq,
  output logic        overrun
);
  localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   acc_q, acc_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          ovr_q, ovr_d;

  logic [1:0]    sel;
  logic          ctrl_wr, flush, clr_ovr, pop, push, drop;
  word_t         push_word, head;
  logic          empty, full;
  logic [LW-1:0] level;
  logic [7:0]    level8;
  logic          unused_bits;

  assign unused_bits = ^{address[15:4], address[1:0], w_data[31:2]};

  assign sel     = address[3:2];
  assign ctrl_wr = we && (sel == REG_CTRL);
  assign flush   = ctrl_wr && w_data[FLUSH_BIT];
  assign clr_ovr = ctrl_wr && w_data[CLR_OVR_BIT];
  assign pop     = re && (sel == REG_DATA) && !empty;
  assign drop    = push && !flush && full && !pop;

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    idle_d    = idle_q;
    push      = 1'b0;
    push_word = '0;
    if (rx_done_tick) begin
      idle_d = '0;
      if (cnt_q == 2'd3) begin
        push      = 1'b1;
        push_word = '{bcnt: 3'd4, data: {rx_data, acc_q}};
        cnt_d     = '0;
        acc_d     = '0;
      end else begin
        acc_d[{cnt_q, 3'b000} +: 8] = rx_data;
        cnt_d                       = cnt_q + 1'b1;
      end
    end else if (cnt_q != 2'd0) begin
      // Push on the edge where the idle count would reach TIMEOUT-1.
      if (idle_q == IW'(TIMEOUT - 2)) begin
        push      = 1'b1;
        push_word = '{bcnt: {1'b0, cnt_q}, data: {8'h00, acc_q}};
        cnt_d     = '0;
        acc_d     = '0;
        idle_d    = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
    if (flush) begin
      cnt_d  = '0;
      acc_d  = '0;
      idle_d = '0;
    end
    ovr_d = drop | (ovr_q & ~clr_ovr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      idle_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      idle_q <= idle_d;
      ovr_q  <= ovr_d;
    end
  end

  word_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .din     (push_word),
    .dout    (head),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  always_comb begin
    level8            = '0;
    level8[LW-1:0]    = level;
    r_data            = '0;
    case (sel)
      REG_DATA:   r_data = empty ? 32'h0 : head.data;
      REG_STATUS: begin
        r_data[LEVEL_LSB +: 8] = level8;
        r_data[EMPTY_BIT]      = empty;
        r_data[FULL_BIT]       = full;
        r_data[OVR_BIT]        = ovr_q;
        r_data[BCNT_LSB +: 3]  = empty ? 3'd0 : head.bcnt;
      end
      REG_CTRL:   r_data[2:0] = {1'b0, cnt_q};
      default:    r_data = '0;
    endcase
  end

  assign irq     = !empty;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Randomized and directed bench for uart_rx_packer against a queue-based reference model.
module tb_uart_rx_packer;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic [15:0] address;
  logic        re, we;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        irq, overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queued words as {bytecount, data}, pending bytes, idle cycles, sticky overrun.
  logic [34:0] mq[$];
  logic [7:0]  pend[$];
  int          m_idle;
  bit          m_ovr;

  uart_rx_packer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .address      (address),
    .re           (re),
    .we           (we),
    .w_data       (w_data),
    .r_data       (r_data),
    .irq          (irq),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      2'd0: if (mq.size() != 0) v = mq[0][31:0];
      2'd1: begin
        v[7:0]  = 8'(mq.size());
        v[8]    = (mq.size() == 0);
        v[9]    = (mq.size() == DEPTH);
        v[10]   = m_ovr;
        v[13:11] = (mq.size() != 0) ? mq[0][34:32] : 3'd0;
      end
      2'd2: v = 32'(pend.size());
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_idle = 0;
    m_ovr  = 1'b0;
  endtask

  task automatic model_edge(input bit tk, input logic [7:0] b, input bit r,
                            input logic [1:0] a, input bit w, input logic [31:0] wd);
    bit          have, do_pop, do_flush, do_clr, dropped;
    logic [31:0] d;
    logic [34:0] word;
    have     = 1'b0;
    word     = '0;
    do_pop   = r && (a == 2'd0) && (mq.size() != 0);
    do_flush = w && (a == 2'd2) && wd[1];
    do_clr   = w && (a == 2'd2) && wd[0];
    if (tk) begin
      pend.push_back(b);
      m_idle = 0;
    end else if (pend.size() != 0) begin
      m_idle++;
    end
    if (pend.size() == 4 || (pend.size() != 0 && !tk && m_idle == TIMEOUT - 1)) begin
      d = 32'h0;
      foreach (pend[i]) d |= 32'(pend[i]) << (8 * i);
      word = {3'(pend.size()), d};
      have = 1'b1;
      pend.delete();
      m_idle = 0;
    end
    if (do_flush) begin
      mq.delete();
      pend.delete();
      m_idle = 0;
      m_ovr  = m_ovr && !do_clr;
    end else begin
      dropped = have && (mq.size() == DEPTH) && !do_pop;
      if (do_pop) void'(mq.pop_front());
      if (have && !dropped) mq.push_back(word);
      m_ovr = dropped || (m_ovr && !do_clr);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model at the rising edge.
  task automatic step(input bit tk, input logic [7:0] b, input bit r,
                      input logic [1:0] a, input bit w, input logic [31:0] wd);
    logic [15:0] ad;
    ad           = 16'($urandom);
    ad[3:2]      = a;
    address      = ad;
    rx_done_tick = tk;
    rx_data      = tk ? b : 8'($urandom);
    re           = r;
    we           = w;
    w_data       = wd;
    @(negedge clk);
    check($sformatf("r_data[a=%0d]", a), r_data, exp_rdata(a));
    check("irq", 32'(irq), 32'(mq.size() != 0));
    check("overrun", 32'(overrun), 32'(m_ovr));
    @(posedge clk);
    model_edge(tk, b, r, a, w, wd);
    #1;
    rx_done_tick = 1'b0;
    re           = 1'b0;
    we           = 1'b0;
  endtask

  task automatic feed(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) step(1'b1, 8'($urandom), 1'b0, a, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, a, 1'b0, 32'h0);
  endtask

  task automatic drain();
    while (mq.size() != 0) step(1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    logic [7:0] seq [4];
    model_reset();
    reset_n      = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    address      = 16'h0004;
    re           = 1'b0;
    we           = 1'b0;
    w_data       = 32'h0;
    #12;
    check("reset status", r_data, 32'h0000_0100);
    check("reset irq", 32'(irq), 32'h0);
    #11 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(2, 2'd1);
    idle(1, 2'd0);

    // Four bytes ten cycles apart form one word.
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i], 1'b0, 2'd1, 1'b0, 32'h0);
      if (i < 3) idle(9, 2'd2);
    end
    step(1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 32'h0);
    check("word 0x44332211", r_data, 32'h0000_2001);
    step(1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 32'h0);
    step(1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 32'h0);

    // Partial word flushed by the idle timeout.
    step(1'b1, 8'hAA, 1'b0, 2'd2, 1'b0, 32'h0);
    step(1'b1, 8'hBB, 1'b0, 2'd2, 1'b0, 32'h0);
    idle(TIMEOUT - 2, 2'd1);
    idle(1, 2'd2);
    check("timeout head", exp_rdata(2'd0), 32'h0000_BBAA);
    step(1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 32'h0);
    step(1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 32'h0);

    // Nine words into a depth-8 FIFO, drain, then clear overrun.
    feed(36, 2'd1);
    idle(1, 2'd1);
    drain();
    step(1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 32'h1);
    idle(1, 2'd1);

    // Full FIFO: last byte of a word arrives together with a DATA read.
    feed(35, 2'd1);
    step(1'b1, 8'h5D, 1'b1, 2'd0, 1'b0, 32'h0);
    idle(1, 2'd1);
    drain();

    // Flush with two queued words, three pending bytes and a concurrent byte.
    feed(11, 2'd1);
    step(1'b1, 8'h77, 1'b0, 2'd2, 1'b1, 32'h2);
    idle(1, 2'd1);
    idle(1, 2'd2);

    // Asynchronous reset mid-word, between clock edges.
    feed(6, 2'd1);
    address = 16'h0004;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async rst status", r_data, 32'h0000_0100);
    check("async rst irq", 32'(irq), 32'h0);
    check("async rst overrun", 32'(overrun), 32'h0);
    address = 16'h0008;
    #1;
    check("async rst pending", r_data, 32'h0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    feed(4, 2'd1);
    idle(1, 2'd1);
    check("one word after reset", exp_rdata(2'd1), 32'h0000_2001);
    drain();

    // Randomized traffic with occasional idle gaps around the timeout.
    gap = 0;
    for (int c = 0; c < 3000; c++) begin
      bit tk;
      if (gap > 0) begin
        gap--;
        tk = 1'b0;
      end else begin
        tk = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 59) == 0) gap = $urandom_range(TIMEOUT - 3, TIMEOUT + 3);
      end
      step(tk, 8'($urandom), ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 40) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
